// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse word generator.
// Optional abort input is enabled by defining PULSE_GEN_ABORT_EN.
package pulse_gen_pkg;

  localparam int unsigned PKG_W_LEN = 16;
  localparam int unsigned PKG_W_CNT = 16;
  localparam int unsigned LEN_MIN   = 1;

  typedef logic [PKG_W_LEN-1:0] len_t;
  typedef logic [PKG_W_CNT-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pulse_word_slicer.sv
// Combinational slicer: advances the pulse-train state by N_OUT samples, MSB first,
// producing one output word and the state for the following word.
module pulse_word_slicer #(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned W_LEN = 16,
  parameter int unsigned W_CNT = 16
) (
  input  logic             level,
  input  logic [W_LEN-1:0] remaining,
  input  logic [W_CNT-1:0] pulses_left,
  input  logic [W_LEN-1:0] high_len,
  input  logic [W_LEN-1:0] low_len,
  output logic [N_OUT-1:0] word,
  output logic             level_nxt,
  output logic [W_LEN-1:0] remaining_nxt,
  output logic [W_CNT-1:0] pulses_left_nxt,
  output logic             stop
);

  always_comb begin
    logic             lvl;
    logic [W_LEN-1:0] rem;
    logic [W_CNT-1:0] pl;
    logic             stp;
    lvl  = level;
    rem  = remaining;
    pl   = pulses_left;
    stp  = 1'b0;
    word = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      // A train with nothing left stops at once; later bits stay low.
      if (!stp && (pl == '0)) stp = 1'b1;
      if (!stp) begin
        // Zero-length low phase only arises from offset 0: go straight to high.
        if (!lvl && (rem == '0)) begin
          lvl = 1'b1;
          rem = high_len;
        end
        word[i] = lvl;
        rem = (rem != '0) ? rem - W_LEN'(1) : '0;
        if (rem == '0) begin
          if (lvl) begin
            pl = (pl != '0) ? pl - W_CNT'(1) : '0;
            if (pl == '0) begin
              stp = 1'b1;
            end else begin
              lvl = 1'b0;
              rem = low_len;
            end
          end else begin
            lvl = 1'b1;
            rem = high_len;
          end
        end
      end
    end
    level_nxt       = lvl;
    remaining_nxt   = rem;
    pulses_left_nxt = pl;
    stop            = stp;
  end

endmodule

// File: rtl/pulse_word_generator.sv
// Programmed rectangular pulse-train generator emitting N_OUT-sample words for a serializer.
// Defining PULSE_GEN_ABORT_EN adds an abort input that ends a running train early.
module pulse_word_generator
  import pulse_gen_pkg::*;
#(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned W_LEN = 16,
  parameter int unsigned W_CNT = 16,
  localparam int unsigned W_OFF = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W_LEN-1:0] cmd_high_len,
  input  logic [W_LEN-1:0] cmd_low_len,
  input  logic [W_CNT-1:0] cmd_count,
  input  logic [W_OFF-1:0] cmd_offset,
`ifdef PULSE_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic [N_OUT-1:0] dout,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic             level_q, level_d;
  logic [W_LEN-1:0] rem_q, rem_d;
  logic [W_CNT-1:0] pl_q, pl_d;
  logic [W_LEN-1:0] high_q, high_d;
  logic [W_LEN-1:0] low_q, low_d;
  logic [N_OUT-1:0] dout_d;
  logic             busy_d, done_d, ready_d;

  logic             accept;
  logic             abort_run;
  logic [N_OUT-1:0] slc_word;
  logic             slc_level, slc_stop;
  logic [W_LEN-1:0] slc_rem;
  logic [W_CNT-1:0] slc_pl;

  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready;

`ifdef PULSE_GEN_ABORT_EN
  assign abort_run = (state_q == RUN) && abort;
`else
  assign abort_run = 1'b0;
`endif

  pulse_word_slicer #(
    .N_OUT (N_OUT),
    .W_LEN (W_LEN),
    .W_CNT (W_CNT)
  ) u_slicer (
    .level           (level_q),
    .remaining       (rem_q),
    .pulses_left     (pl_q),
    .high_len        (high_q),
    .low_len         (low_q),
    .word            (slc_word),
    .level_nxt       (slc_level),
    .remaining_nxt   (slc_rem),
    .pulses_left_nxt (slc_pl),
    .stop            (slc_stop)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (abort_run || slc_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs
  always_comb begin
    level_d = level_q;
    rem_d   = rem_q;
    pl_d    = pl_q;
    high_d  = high_q;
    low_d   = low_q;
    dout_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = !accept;
        if (accept) begin
          level_d = 1'b0;
          rem_d   = W_LEN'(cmd_offset);
          pl_d    = cmd_count;
          high_d  = (cmd_high_len == '0) ? W_LEN'(LEN_MIN) : cmd_high_len;
          low_d   = (cmd_low_len == '0) ? W_LEN'(LEN_MIN) : cmd_low_len;
        end
      end
      RUN: begin
        if (abort_run) begin
          done_d = 1'b1;
        end else begin
          dout_d  = slc_word;
          done_d  = slc_stop;
          busy_d  = !slc_stop;
          level_d = slc_level;
          rem_d   = slc_rem;
          pl_d    = slc_pl;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q   <= 1'b0;
      rem_q     <= '0;
      pl_q      <= '0;
      high_q    <= '0;
      low_q     <= '0;
      dout      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      level_q   <= level_d;
      rem_q     <= rem_d;
      pl_q      <= pl_d;
      high_q    <= high_d;
      low_q     <= low_d;
      dout      <= dout_d;
      busy      <= busy_d;
      done      <= done_d;
      cmd_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_pulse_word_generator.sv
// Directed bench for pulse_word_generator (N_OUT = 4) with a queue of expected words
// built from a sample-stream reference model; abort cases need PULSE_GEN_ABORT_EN.
module tb_pulse_word_generator;
  import pulse_gen_pkg::*;

  typedef struct packed {
    logic [3:0] word;
    logic       done;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  len_t       cmd_high_len;
  len_t       cmd_low_len;
  cnt_t       cmd_count;
  logic [1:0] cmd_offset;
`ifdef PULSE_GEN_ABORT_EN
  logic       abort;
`endif
  logic [3:0] dout;
  logic       busy;
  logic       done;

  int   vectors = 0;
  int   errs    = 0;
  exp_t exp_q[$];

  pulse_word_generator #(
    .N_OUT (4),
    .W_LEN (PKG_W_LEN),
    .W_CNT (PKG_W_CNT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_high_len (cmd_high_len),
    .cmd_low_len  (cmd_low_len),
    .cmd_count    (cmd_count),
    .cmd_offset   (cmd_offset),
`ifdef PULSE_GEN_ABORT_EN
    .abort        (abort),
`endif
    .dout         (dout),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: build the full sample stream, cut it into MSB-first words.
  task automatic issue(input int h, input int l, input int c, input int o);
    int   hh, ll, nw, n;
    bit   bits[$];
    exp_t e;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    for (int k = 0; k < o; k++) bits.push_back(1'b0);
    for (int p = 0; p < c; p++) begin
      for (int k = 0; k < hh; k++) bits.push_back(1'b1);
      if (p != c - 1) for (int k = 0; k < ll; k++) bits.push_back(1'b0);
    end
    nw = (bits.size() + 3) / 4;
    if (nw == 0) nw = 1;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 4; b++)
        e.word[3-b] = (4 * w + b < bits.size()) ? bits[4*w+b] : 1'b0;
      e.done = (w == nw - 1);
      e.busy = !e.done;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_high_len = len_t'(h);
    cmd_low_len  = len_t'(l);
    cmd_count    = cnt_t'(c);
    cmd_offset   = 2'(o);
    cmd_valid    = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("lat.dout", 32'(dout), 0);
    check("lat.busy", 32'(busy), 0);
    check("lat.ready", 32'(cmd_ready), 0);
  endtask

  task automatic step_word(input string tag);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, ".qsize"}, 32'(exp_q.size()), 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".dout"}, 32'(dout), 32'(e.word));
    check({tag, ".done"}, 32'(done), 32'(e.done));
    check({tag, ".busy"}, 32'(busy), 32'(e.busy));
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0) begin
      step_word($sformatf("%s.w%0d", tag, k));
      k++;
    end
    @(negedge clk);
    check({tag, ".idle.dout"}, 32'(dout), 0);
    check({tag, ".idle.done"}, 32'(done), 0);
    check({tag, ".idle.busy"}, 32'(busy), 0);
    check({tag, ".idle.ready"}, 32'(cmd_ready), 1);
  endtask

  initial begin
    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_high_len = '0;
    cmd_low_len  = '0;
    cmd_count    = '0;
    cmd_offset   = '0;
`ifdef PULSE_GEN_ABORT_EN
    abort        = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst.dout", 32'(dout), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.ready", 32'(cmd_ready), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("rst.ready_rise", 32'(cmd_ready), 1);

    // Directed trains: two 2/2 pulses, offset start, single-sample pulses
    issue(2, 2, 2, 0); drain("t1");
    issue(4, 1, 1, 1); drain("t2");
    issue(1, 1, 3, 0); drain("t3");
    // Zero pulses, with and without offset: one empty word carrying done
    issue(5, 5, 0, 0); drain("t4a");
    issue(5, 5, 0, 2); drain("t4b");
    // Train ending exactly on the last bit of its first word
    issue(3, 5, 1, 1); drain("edge");
    // Zero lengths clamp to one sample
    issue(0, 0, 2, 3); drain("clamp");

    // Reset in the third word of a long train
    issue(100, 1, 5, 0);
    step_word("rs.w0");
    step_word("rs.w1");
    step_word("rs.w2");
    #1 reset_n = 1'b0;
    #1;
    check("rs.dout", 32'(dout), 0);
    check("rs.busy", 32'(busy), 0);
    check("rs.done", 32'(done), 0);
    check("rs.ready", 32'(cmd_ready), 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rs.ready_rise", 32'(cmd_ready), 1);
    check("rs.post_done", 32'(done), 0);

    for (int r = 0; r < 5; r++) begin
      issue(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      drain($sformatf("rnd%0d", r));
    end

`ifdef PULSE_GEN_ABORT_EN
    // Abort in word 2 with cmd_valid held high throughout
    issue(8, 8, 4, 0);
    exp_q.delete();
    exp_q.push_back('{word: 4'hF, done: 1'b0, busy: 1'b1});
    exp_q.push_back('{word: 4'hF, done: 1'b0, busy: 1'b1});
    exp_q.push_back('{word: 4'h0, done: 1'b1, busy: 1'b0});
    cmd_valid = 1'b1;
    step_word("ab.w0");
    step_word("ab.w1");
    abort = 1'b1;
    step_word("ab.w2");
    abort = 1'b0;
    @(negedge clk);
    check("ab.idle.ready", 32'(cmd_ready), 1);
    check("ab.idle.dout", 32'(dout), 0);
    check("ab.idle.busy", 32'(busy), 0);
    @(negedge clk);
    check("ab.reaccept", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("ab.restart.dout", 32'(dout), 32'hF);
    check("ab.restart.busy", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab.stop.dout", 32'(dout), 0);
    check("ab.stop.done", 32'(done), 1);
    @(negedge clk);
    check("ab.end.ready", 32'(cmd_ready), 1);
    check("ab.end.done", 32'(done), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/pulse_word_generator.md
# pulse_word_generator

Transmit-side counterpart of the deserialized rising-edge detector. Generates a programmed train of rectangular pulses as parallel N_OUT-sample words, MSB = earliest sample, one word per `clk`, to feed an output serializer. Pulse timing has single-sample resolution, including the start position inside the first word. Loopback through serializer, deserializer and edge detector closes the test path.

## Interface
- `N_OUT`, default 4: samples per output word; bit N_OUT-1 is transmitted first.
- `W_LEN`, default 16: width of the high/low length fields, in samples.
- `W_CNT`, default 16: width of the pulse-count field.

- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command can be accepted.
- `cmd_high_len` in W_LEN: high samples per pulse; 0 treated as 1.
- `cmd_low_len` in W_LEN: low samples between pulses; 0 treated as 1.
- `cmd_count` in W_CNT: number of pulses; 0 is legal and produces none.
- `cmd_offset` in $clog2(N_OUT): leading low samples before pulse 1, within the first word.
- `dout` out N_OUT: registered sample word.
- `busy` out 1: generation in progress.
- `done` out 1: one-cycle completion strobe, aligned with the final word of a command.

## Operation
- FSM states in `pulse_gen_pkg::state_t`: IDLE, RUN.
- **IDLE**
  - `cmd_ready` = 1 and `dout` = 0.
  - Acceptance requires `cmd_valid && cmd_ready` on a clock edge. On acceptance: latch all fields, set level = low with remaining = cmd_offset, set pulses_left = cmd_count, go to RUN.
- **RUN**
  - Each cycle, fill N_OUT bits, MSB first, sample by sample.
  - A sample emits the current level, then decrements remaining.
  - When remaining reaches 0 on low: switch to high with remaining = high_len.
  - When remaining reaches 0 on high: decrement pulses_left. If pulses_left is then 0, stop. Otherwise switch to low with remaining = low_len.
  - An offset-0 leading low phase is skipped, so pulse 1 starts at bit N_OUT-1.
  - After the stop sample, every remaining bit of that word is 0. That word carries `done` = 1, and the FSM returns to IDLE.
  - No trailing low_len is appended after the last pulse.
- **cmd_count = 0**: accepted normally. Next word is 0000…, with `done` = 1 on the same word, then IDLE.
- **Arithmetic**
  - Counters are unsigned and saturate at 0; they never wrap.
  - Lengths of 0 are clamped to 1 at latch time.
- `cmd_valid` while busy is ignored; it is not queued.

## Timing
- Reset values: `dout` = 0, `busy` = 0, `done` = 0, `cmd_ready` = 0. State is IDLE.
- `cmd_ready` is registered and rises on the first `clk` edge after `reset_n` deasserts.
- Command accepted at edge T:
  - the first generated word appears on `dout` after edge T+1;
  - `busy` = 1 from T+1 until the edge that presents the `done` word.
- `done` and the final word share one cycle. `busy` = 0 and `cmd_ready` = 1 from the next edge.
- The earliest next acceptance is the cycle after `done`. The minimum gap between trains is one all-zero word.
- Asserting `reset_n` = 0 mid-train forces `dout` = 0 immediately (asynchronous). `done` is not emitted.

## Configuration
- `PULSE_GEN_ABORT_EN`
  - **Defined**: adds input `abort` (1 bit). While `busy`, `abort` = 1 at edge E makes the word after E all zero, with `done` = 1, then IDLE. `abort` in IDLE has no effect. `abort` and an accept in the same cycle: accept wins.
  - **Undefined**: no `abort` port. A train always runs to completion.

## Structure
- `pulse_gen_pkg` holds:
  - `state_t`;
  - the `len_t` and `cnt_t` typedefs, sized by W_LEN and W_CNT parameters;
  - a constant for the length-clamp minimum (1).
- Sub-module `pulse_word_slicer` is purely combinational. Given level, remaining and pulses_left, it produces the N_OUT-bit word plus the next level, remaining, pulses_left and stop flag. The top module holds the FSM, registers and handshake.

## Test plan
All cases use N_OUT = 4.
1. high=2, low=2, count=2, offset=0 → words 1100, 1100 (`done` on the 2nd), then 0000.
2. high=4, low=1, count=1, offset=1 → words 0111, 1000 (`done` on the 2nd).
3. high=1, low=1, count=3, offset=0 → words 1010, 1000 (`done`). Loopback edge detector flags both words.
4. count=0 → next word 0000 with `done` = 1. `cmd_ready` = 1 on the following cycle; `busy` never rises.
5. high=100, count=5, `reset_n` pulsed low in the 3rd word → `dout` = 0 immediately, no `done`. `cmd_ready` = 1 one edge after release.
6. With `PULSE_GEN_ABORT_EN` defined: high=8, low=8, count=4, `abort` in word 2 → word 3 = 0000 with `done`, then IDLE. `cmd_valid` held high during busy is ignored until `done`.
